// File: rtl/point_double_seq.sv
// point_double_seq: secp256k1 affine point doubling sequenced over one shared field ALU
module point_double_seq #(
    parameter int WIDTH = 256,
    parameter int WDOG  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             in_inf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic             out_inf,
    output logic             err,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    state_t state, nxt;
    logic [3:0] step;
    logic [31:0] wd;
    logic [WIDTH-1:0] xr, yr, t0, t1, t2, lr, x3r;
    logic shortcut, expired;

    assign shortcut = in_inf || (y1 == '0);
    assign expired = (WDOG != 0) && (wd == 32'(WDOG - 1));

    // Next state, handshake outputs and the per-step operand mux (operands are stable while WAIT)
    always_comb begin
        nxt = state;
        busy = (state != IDLE);
        done = (state == DONE);
        alu_start = (state == ISSUE);
        alu_op = OP_MUL;
        alu_a = xr;
        alu_b = xr;
        case (step)
            4'd1: begin alu_a = THREE; alu_b = t0; end
            4'd2: begin alu_a = TWO; alu_b = yr; end
            4'd3: begin alu_op = OP_INV; alu_a = t2; alu_b = '0; end
            4'd4: begin alu_a = t1; alu_b = t2; end
            4'd5: begin alu_a = lr; alu_b = lr; end
            4'd6: begin alu_a = TWO; alu_b = xr; end
            4'd7: begin alu_op = OP_SUB; alu_a = t0; alu_b = t1; end
            4'd8: begin alu_op = OP_SUB; alu_a = xr; alu_b = x3r; end
            4'd9: begin alu_a = lr; alu_b = t0; end
            4'd10: begin alu_op = OP_SUB; alu_a = t1; alu_b = yr; end
            default: ;
        endcase
        case (state)
            IDLE: nxt = start ? (shortcut ? DONE : ISSUE) : IDLE;
            ISSUE: nxt = WAIT;
            WAIT: nxt = alu_done ? ((step == 4'd10) ? DONE : ISSUE) : (expired ? DONE : WAIT);
            default: nxt = IDLE;
        endcase
    end

    // State, operand capture, result write-back and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step <= '0;
            wd <= '0;
            xr <= '0;
            yr <= '0;
            t0 <= '0;
            t1 <= '0;
            t2 <= '0;
            lr <= '0;
            x3r <= '0;
            x3 <= '0;
            y3 <= '0;
            out_inf <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (start) begin
                    xr <= x1;
                    yr <= y1;
                    step <= '0;
                    err <= 1'b0;
                    out_inf <= shortcut;
                    if (shortcut) begin
                        x3 <= '0;
                        y3 <= '0;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: if (alu_done) begin
                    step <= step + 4'd1;
                    case (step)
                        4'd0, 4'd5, 4'd8: t0 <= alu_result;
                        4'd1, 4'd6, 4'd9: t1 <= alu_result;
                        4'd2, 4'd3: t2 <= alu_result;
                        4'd4: lr <= alu_result;
                        4'd7: x3r <= alu_result;
                        4'd10: begin
                            x3 <= x3r;
                            y3 <= alu_result;
                        end
                        default: ;
                    endcase
                end else begin
                    wd <= wd + 32'd1;
                    if (expired) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_point_double_seq.sv
// tb_point_double_seq: directed bench with a behavioural field ALU and a textbook doubling model
module tb_point_double_seq;
    localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [21:0] OPSEQ = {2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};

    logic clk = 1'b0;
    logic rst, start, in_inf, busy, done, out_inf, err, alu_start, alu_done;
    logic [255:0] x1, y1, x3, y3, alu_a, alu_b, alu_result;
    logic [1:0] alu_op;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int rem, n_starts, alu_lat, stray_cyc, c0;
    bit alu_rnd, alu_mute;
    logic [255:0] lat_a, lat_b, res, exp_x3, exp_y3, m2x, m2y, m4x, m4y;
    logic [1:0] lat_op;
    logic [21:0] ops_seen;
    logic exp_inf, exp_err;

    point_double_seq #(.WIDTH(256), .WDOG(16)) dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .y1(y1), .in_inf(in_inf),
        .busy(busy), .done(done), .x3(x3), .y3(y3), .out_inf(out_inf), .err(err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        t = t % {256'd0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        t = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, P} - {1'b0, b};
        return t[255:0];
    endfunction

    function automatic logic [255:0] invm(input logic [255:0] a);
        logic [255:0] r, base, e;
        r = 256'd1;
        base = a;
        e = P - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulm(r, base);
            base = mulm(base, base);
        end
        return r;
    endfunction

    function automatic logic [255:0] alu_f(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b);
        return (op == 2'd0) ? mulm(a, b) : (op == 2'd1) ? subm(a, b) : invm(a);
    endfunction

    // lambda = 3x^2 / 2y ; x3 = lambda^2 - 2x ; y3 = lambda(x - x3) - y
    task automatic dbl(input logic [255:0] x, input logic [255:0] y, output logic [255:0] rx, output logic [255:0] ry);
        logic [255:0] l;
        l = mulm(mulm(256'd3, mulm(x, x)), invm(mulm(256'd2, y)));
        rx = subm(mulm(l, l), mulm(256'd2, x));
        ry = subm(mulm(l, subm(x, rx)), y);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Behavioural ALU: answers each issue after a fixed or random latency, or never when muted
    initial begin
        alu_done = 1'b0;
        alu_result = '0;
        rem = 0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (rst || done) rem = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    alu_done = 1'b1;
                    alu_result = res;
                end
            end
            if (cyc == stray_cyc) begin
                alu_done = 1'b1;
                alu_result = '1;
            end
            if (alu_start && !rst) begin
                lat_a = alu_a;
                lat_b = alu_b;
                lat_op = alu_op;
                n_starts++;
                ops_seen = {ops_seen[19:0], alu_op};
                res = alu_f(alu_op, alu_a, alu_b);
                rem = alu_mute ? 1000000 : (alu_rnd ? int'($urandom_range(9, 1)) : alu_lat);
            end
        end
    end

    // Compare process: results on every done cycle, operand stability on every WAIT cycle
    initial forever begin
        @(posedge clk);
        #2;
        if (done) begin
            chk("done_x3", x3, exp_x3);
            chk("done_y3", y3, exp_y3);
            chk("done_inf", 256'(out_inf), 256'(exp_inf));
            chk("done_err", 256'(err), 256'(exp_err));
        end
        if (rem > 0 && busy && !done) begin
            chk("hold_a", alu_a, lat_a);
            chk("hold_b", alu_b, lat_b);
            chk("hold_op", 256'(alu_op), 256'(lat_op));
        end
    end

    task automatic run(input string tag, input logic [255:0] x, input logic [255:0] y, input logic inf,
                       input int lat, input bit rnd, input bit extra, input bit mute, input int exp_cyc,
                       input logic [255:0] ex, input logic [255:0] ey, input logic einf, input logic eerr,
                       input int exp_starts, input bit chk_ops);
        int got;
        int rel;
        alu_lat = lat;
        alu_rnd = rnd;
        alu_mute = mute;
        n_starts = 0;
        ops_seen = '0;
        exp_x3 = ex;
        exp_y3 = ey;
        exp_inf = einf;
        exp_err = eerr;
        @(negedge clk);
        #1;
        start = 1'b1;
        x1 = x;
        y1 = y;
        in_inf = inf;
        c0 = cyc;
        got = -1;
        for (int k = 0; k < 300 && got < 0; k++) begin
            @(negedge clk);
            #1;
            rel = cyc - c0;
            start = extra && (rel == 5 || rel == 20);
            x1 = ~x;
            y1 = ~y;
            in_inf = 1'b0;
            if (rel == 1) begin
                chk({tag, "_busy1"}, 256'(busy), 256'(1));
                chk({tag, "_err1"}, 256'(err), 256'(0));
            end
            if (done) got = rel;
        end
        start = 1'b0;
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 256'(got), 256'(exp_cyc));
        else chk({tag, "_done_seen"}, 256'(got > 0), 256'(1));
        chk({tag, "_starts"}, 256'(n_starts), 256'(exp_starts));
        if (chk_ops) chk({tag, "_ops"}, 256'(ops_seen), 256'(OPSEQ));
        @(negedge clk);
        #1;
        chk({tag, "_after_done"}, 256'(done), 256'(0));
        chk({tag, "_after_busy"}, 256'(busy), 256'(0));
    endtask

    task automatic rst_run();
        int rel;
        logic bad;
        alu_lat = 3;
        alu_rnd = 1'b0;
        alu_mute = 1'b0;
        n_starts = 0;
        ops_seen = '0;
        bad = 1'b0;
        @(negedge clk);
        #1;
        start = 1'b1;
        x1 = GX;
        y1 = GY;
        in_inf = 1'b0;
        c0 = cyc;
        stray_cyc = c0 + 16;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            rel = cyc - c0;
            start = 1'b0;
            if (rel == 15) rst = 1'b1;
            if (rel == 16) rst = 1'b0;
            if (rel >= 16) bad = bad | busy | done | alu_start;
        end
        stray_cyc = -1;
        chk("rst_quiet", 256'(bad), 256'(0));
        chk("rst_starts", 256'(n_starts), 256'(4));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_inf = 1'b0;
        x1 = '0;
        y1 = '0;
        stray_cyc = -1;
        alu_lat = 3;
        alu_rnd = 1'b0;
        alu_mute = 1'b0;
        n_starts = 0;
        ops_seen = '0;
        exp_x3 = '0;
        exp_y3 = '0;
        exp_inf = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_alu_start", 256'(alu_start), 256'(0));
        chk("rst_out_inf", 256'(out_inf), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_x3", x3, 256'(0));
        chk("rst_y3", y3, 256'(0));
        chk("rst_alu_a", alu_a, 256'(0));
        chk("rst_alu_b", alu_b, 256'(0));
        chk("rst_alu_op", 256'(alu_op), 256'(0));
        rst = 1'b0;

        dbl(GX, GY, m2x, m2y);
        chk("model_2g_x", m2x, G2X);
        chk("model_2g_y", m2y, G2Y);
        dbl(m2x, m2y, m4x, m4y);

        run("g", GX, GY, 1'b0, 3, 1'b0, 1'b0, 1'b0, 45, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        run("inf", GX, GY, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1, '0, '0, 1'b1, 1'b0, 0, 1'b0);
        run("y0", GX, '0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1, '0, '0, 1'b1, 1'b0, 0, 1'b0);
        run("g_restart", GX, GY, 1'b0, 3, 1'b0, 1'b1, 1'b0, 45, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        rst_run();
        run("g_after_rst", GX, GY, 1'b0, 3, 1'b0, 1'b0, 1'b0, 45, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        run("wdog", GX, GY, 1'b0, 3, 1'b0, 1'b0, 1'b1, 18, m2x, m2y, 1'b0, 1'b1, 1, 1'b0);
        chk("wdog_err_sticky", 256'(err), 256'(1));
        chk("wdog_out_inf", 256'(out_inf), 256'(0));
        run("g_clear_err", GX, GY, 1'b0, 3, 1'b0, 1'b0, 1'b0, 45, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        run("g_lat1", GX, GY, 1'b0, 1, 1'b0, 1'b0, 1'b0, 23, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        run("g_rand", GX, GY, 1'b0, 3, 1'b1, 1'b0, 1'b0, -1, m2x, m2y, 1'b0, 1'b0, 11, 1'b1);
        run("g2_rand", m2x, m2y, 1'b0, 3, 1'b1, 1'b0, 1'b0, -1, m4x, m4y, 1'b0, 1'b0, 11, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/point_double_seq.md
Name: point_double_seq

Overview:
- Sequencer that performs secp256k1 affine point doubling (x3,y3) = 2·(x1,y1) by issuing a fixed micro-op program to one shared field ALU (mod_mult / mod_sub / mod_inv behind a start/done handshake).
- Replaces the combinational three-multiplier-plus-inverter doubling datapath with one time-multiplexed ALU.
- Sits between the scalar-multiply controller (the requester) and the field ALU.

Parameters:
- WIDTH, 256, field element width.
- WDOG, 4096, maximum cycles to wait for alu_done per micro-op; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- x1  in  WIDTH  input x, captured on accepted start.
- y1  in  WIDTH  input y, captured on accepted start.
- in_inf  in  1  input is the point at infinity.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- x3  out  WIDTH  result x, registered.
- y3  out  WIDTH  result y, registered.
- out_inf  out  1  result is the point at infinity.
- err  out  1  watchdog expired; sticky until the next accepted start or rst.
- alu_op  out  2  ALU op select: 0 = MUL, 1 = SUB (a−b mod p), 2 = INV (a⁻¹ mod p).
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_start  out  1  one-cycle issue pulse.
- alu_done  in  1  ALU result valid (one-cycle pulse).
- alu_result  in  WIDTH  ALU result.

Behaviour:
- Reset (synchronous): state IDLE; busy, done, alu_start, out_inf, err = 0; x3, y3, alu_a, alu_b = 0; alu_op = 0; internal registers cleared.
- rst while an operation is in flight aborts it immediately, with no done pulse. A late alu_done arriving after the abort is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 captures x1, y1, in_inf into X, Y and an inf flag.
  - If in_inf=1 or y1=0, go to DONE with out_inf=1 and x3 = y3 = 0.
  - Otherwise clear err, set step=0 and go to ISSUE.
- ISSUE: drive alu_op, alu_a, alu_b for the current step; alu_start=1 for exactly this cycle; reset the watchdog counter; go to WAIT.
- WAIT:
  - alu_a, alu_b and alu_op stay held stable.
  - On alu_done, write alu_result to the step's destination register in the same cycle. If step=10 go to DONE, else increment step and go to ISSUE.
  - alu_done is ignored in every state except WAIT.
- DONE: done=1 for one cycle; x3/y3 registers hold the results; go to IDLE. start is ignored whenever the FSM is not in IDLE.
- Program (registers X, Y, T0, T1, T2, L, X3, Y3; constants 2 and 3):
  - 0: T0 = X·X
  - 1: T1 = 3·T0
  - 2: T2 = 2·Y
  - 3: T2 = INV(T2)
  - 4: L = T1·T2
  - 5: T0 = L·L
  - 6: T1 = 2·X
  - 7: X3 = T0 − T1
  - 8: T0 = X − X3
  - 9: T1 = L·T0
  - 10: Y3 = T1 − Y
- Note: the denominator is 2·y, not y.
- Latency: start accepted at cycle 0 with an ALU of fixed latency N (alu_done N cycles after alu_start, N ≥ 1):
  - step k issues at cycle 1 + k(N+1);
  - done at cycle 11(N+1)+1.
  - The infinity/y=0 shortcut gives done at cycle 1.
- Watchdog (WDOG > 0): if WAIT lasts WDOG cycles without alu_done, set err=1 and go to DONE with out_inf=0 and x3/y3 unchanged from their previous values.
- alu_done in the same cycle as rst: rst wins.
- All arithmetic is in the ALU; the sequencer only does register muxing, holding no modulus logic.

Test Plan:
- G = (79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8), behavioural ALU with N=3 -> done at cycle 45; x3 = C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, y3 = 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A; out_inf=0; exactly 11 alu_start pulses with op sequence M,M,M,I,M,M,M,S,S,M,S.
- in_inf=1, or y1=0 -> done at cycle 1, out_inf=1, x3=y3=0, no alu_start.
- start pulsed again at cycles 5 and 20 during the G run -> ignored; results and timing identical to the first scenario.
- rst at cycle 15 of a run, then a stray alu_done at cycle 16 -> busy=0, no done, stays IDLE; a fresh G run then matches the first scenario.
- WDOG=16, ALU never answers -> err=1 and done at cycle 18; the next start clears err.
- Random ALU latency 1–9 per op -> results still equal 2G; each operand held stable throughout WAIT.
